// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream realignment datapath.
// ctrl_realign_t      : per-word control bundle consumed by the stream realigner.
// ctrl_realign_seq_t  : job configuration bundle of the realign sequencer.
// flags_realign_seq_t : status flags (busy, done) of the realign sequencer.
// realign_seq_state_t : sequencer FSM encoding.
package hwpe_stream_package;

    typedef struct packed {
        logic        enable;
        logic        strb_valid;
        logic        realign;
        logic        first;
        logic        last;
        logic        last_packet;
        logic [15:0] line_length;
    } ctrl_realign_t;

    typedef struct packed {
        logic [31:0] base_addr;
        logic [15:0] line_len;
        logic [31:0] line_stride;
        logic [15:0] n_lines;
    } ctrl_realign_seq_t;

    typedef struct packed {
        logic busy;
        logic done;
    } flags_realign_seq_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } realign_seq_state_t;

endpackage

// File: rtl/hwpe_stream_realign_strbgen.sv
// Byte-strobe generator for one word of a realigned line.
// off   : byte offset of the line start inside its first word.
// tail  : byte position just past the line end inside its last word (0 = word full).
// first : the word is the first of its line.
// last  : the word is the last of its line.
// strb  : resulting byte strobe (AND of both masks when first and last coincide).
module hwpe_stream_realign_strbgen #(
    parameter int unsigned BE = 4,
    parameter int unsigned LB = 2
) (
    input  logic [LB-1:0] off,
    input  logic [LB-1:0] tail,
    input  logic          first,
    input  logic          last,
    output logic [BE-1:0] strb
);

    logic [BE-1:0] first_mask_s;
    logic [BE-1:0] last_mask_s;

    // Build head/tail masks and combine them according to word position.
    always_comb begin
        first_mask_s = {BE{1'b1}} << off;
        if (tail == {LB{1'b0}}) begin
            last_mask_s = {BE{1'b1}};
        end else begin
            last_mask_s = ~({BE{1'b1}} << tail);
        end
        strb = {BE{1'b1}};
        if (first) begin
            strb = strb & first_mask_s;
        end else begin
            strb = strb;
        end
        if (last) begin
            strb = strb & last_mask_s;
        end else begin
            strb = strb;
        end
    end

endmodule

// File: rtl/hwpe_stream_realign_sequencer.sv
// Address/strobe sequencer for realigned 2D stream jobs.
// A job of n_lines lines, each line_len bytes starting at base_addr with
// line_stride between line starts, is turned into a sequence of word-aligned
// address requests, each with its byte strobe and realigner control flags.
// Ports:
//   clk_i, rst_i (async, active high), clear_i (sync soft clear)
//   enable_i        : forwarded to ctrl_o.enable
//   start_i         : job start pulse, honoured only when idle
//   base_addr_i, line_len_i, line_stride_i, n_lines_i : job configuration
//   addr_o / addr_valid_o / addr_ready_i : word address request handshake
//   ctrl_o, strb_o  : control flags and strobe of the word on addr_o
//   busy_o, done_o  : job active / one-cycle completion pulse
module hwpe_stream_realign_sequencer
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    enable_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [15:0]             line_len_i,
    input  logic [ADDR_WIDTH-1:0]   line_stride_i,
    input  logic [15:0]             n_lines_i,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    addr_valid_o,
    input  logic                    addr_ready_i,
    output ctrl_realign_t           ctrl_o,
    output logic [DATA_WIDTH/8-1:0] strb_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned BE = DATA_WIDTH / 8;
    localparam int unsigned LB = $clog2(BE);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-LB){1'b1}}, {LB{1'b0}}};

    realign_seq_state_t state_r;
    flags_realign_seq_t flags_r;

    // latched job configuration
    logic [LB-1:0]         off_r;
    logic [LB-1:0]         tail_r;
    logic [16:0]           words_r;
    logic [15:0]           n_lines_r;
    logic [ADDR_WIDTH-1:0] stride_r;

    // walk state
    logic [16:0]           k_r;
    logic [15:0]           j_r;
    logic [ADDR_WIDTH-1:0] line_addr_r;

    // registered outputs
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  valid_r;
    logic [BE-1:0]         strb_r;
    logic                  first_r;
    logic                  last_r;
    logic                  last_packet_r;
    logic                  realign_r;
    logic [15:0]           line_length_r;

    // configuration derived straight from the inputs (used at start)
    logic [LB-1:0]         in_off_s;
    logic [17:0]           in_sum_s;
    logic [16:0]           in_words_s;
    logic [LB-1:0]         in_tail_s;
    logic                  in_empty_s;
    logic                  in_realign_s;
    logic [ADDR_WIDTH-1:0] in_base_s;

    // next-word walk values (used on a handshake in RUN)
    logic [16:0]           nxt_k_s;
    logic [15:0]           nxt_j_s;
    logic                  nxt_first_s;
    logic                  nxt_last_s;
    logic                  nxt_last_packet_s;
    logic [ADDR_WIDTH-1:0] nxt_line_addr_s;
    logic [ADDR_WIDTH-1:0] nxt_addr_s;

    // strobe generator operands
    logic [LB-1:0]         sg_off_s;
    logic [LB-1:0]         sg_tail_s;
    logic                  sg_first_s;
    logic                  sg_last_s;
    logic [BE-1:0]         sg_strb_s;

    // Derive word count, head offset and tail position of a new job.
    always_comb begin
        in_off_s     = base_addr_i[LB-1:0];
        in_sum_s     = 18'(in_off_s) + 18'(line_len_i);
        in_words_s   = 17'((in_sum_s + 18'(BE - 1)) >> LB);
        in_tail_s    = in_sum_s[LB-1:0];
        in_empty_s   = (line_len_i == 16'd0) || (n_lines_i == 16'd0);
        in_realign_s = (in_off_s != {LB{1'b0}});
        in_base_s    = base_addr_i & ALIGN_MASK;
    end

    // Compute the position, address and flags of the word after the current one.
    always_comb begin
        if (last_r) begin
            nxt_k_s         = 17'd0;
            nxt_j_s         = j_r + 16'd1;
            nxt_line_addr_s = line_addr_r + stride_r;
            nxt_addr_s      = line_addr_r + stride_r;
        end else begin
            nxt_k_s         = k_r + 17'd1;
            nxt_j_s         = j_r;
            nxt_line_addr_s = line_addr_r;
            nxt_addr_s      = addr_r + ADDR_WIDTH'(BE);
        end
        nxt_first_s       = (nxt_k_s == 17'd0);
        nxt_last_s        = (nxt_k_s == words_r - 17'd1);
        nxt_last_packet_s = nxt_last_s && (nxt_j_s == n_lines_r - 16'd1);
    end

    // Select strobe operands: fresh config when idle, latched config while running.
    always_comb begin
        if (state_r == SEQ_IDLE) begin
            sg_off_s   = in_off_s;
            sg_tail_s  = in_tail_s;
            sg_first_s = 1'b1;
            sg_last_s  = (in_words_s == 17'd1);
        end else begin
            sg_off_s   = off_r;
            sg_tail_s  = tail_r;
            sg_first_s = nxt_first_s;
            sg_last_s  = nxt_last_s;
        end
    end

    hwpe_stream_realign_strbgen #(
        .BE (BE),
        .LB (LB)
    ) i_strbgen (
        .off   (sg_off_s),
        .tail  (sg_tail_s),
        .first (sg_first_s),
        .last  (sg_last_s),
        .strb  (sg_strb_s)
    );

    // Sequencer FSM with all registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= SEQ_IDLE;
            flags_r       <= '{busy: 1'b0, done: 1'b0};
            off_r         <= {LB{1'b0}};
            tail_r        <= {LB{1'b0}};
            words_r       <= 17'd0;
            n_lines_r     <= 16'd0;
            stride_r      <= {ADDR_WIDTH{1'b0}};
            k_r           <= 17'd0;
            j_r           <= 16'd0;
            line_addr_r   <= {ADDR_WIDTH{1'b0}};
            addr_r        <= {ADDR_WIDTH{1'b0}};
            valid_r       <= 1'b0;
            strb_r        <= {BE{1'b1}};
            first_r       <= 1'b0;
            last_r        <= 1'b0;
            last_packet_r <= 1'b0;
            realign_r     <= 1'b0;
            line_length_r <= 16'd0;
        end else if (clear_i) begin
            state_r       <= SEQ_IDLE;
            flags_r       <= '{busy: 1'b0, done: 1'b0};
            k_r           <= 17'd0;
            j_r           <= 16'd0;
            valid_r       <= 1'b0;
            first_r       <= 1'b0;
            last_r        <= 1'b0;
            last_packet_r <= 1'b0;
        end else begin
            case (state_r)
                SEQ_IDLE: begin
                    flags_r.done <= 1'b0;
                    if (start_i) begin
                        state_r       <= SEQ_RUN;
                        flags_r.busy  <= 1'b1;
                        off_r         <= in_off_s;
                        tail_r        <= in_tail_s;
                        words_r       <= in_words_s;
                        n_lines_r     <= n_lines_i;
                        stride_r      <= line_stride_i & ALIGN_MASK;
                        k_r           <= 17'd0;
                        j_r           <= 16'd0;
                        line_addr_r   <= in_base_s;
                        addr_r        <= in_base_s;
                        // An empty job spends its RUN cycle without a request.
                        valid_r       <= !in_empty_s;
                        strb_r        <= sg_strb_s;
                        first_r       <= 1'b1;
                        last_r        <= (in_words_s == 17'd1);
                        last_packet_r <= (in_words_s == 17'd1) && (n_lines_i == 16'd1);
                        realign_r     <= in_realign_s;
                        line_length_r <= 16'(in_words_s - 17'(in_realign_s));
                    end else begin
                        flags_r.busy  <= 1'b0;
                        valid_r       <= 1'b0;
                    end
                end
                SEQ_RUN: begin
                    if (!valid_r) begin
                        state_r      <= SEQ_DONE;
                        flags_r.done <= 1'b1;
                    end else if (addr_ready_i) begin
                        if (last_packet_r) begin
                            state_r      <= SEQ_DONE;
                            flags_r.done <= 1'b1;
                            valid_r      <= 1'b0;
                        end else begin
                            k_r           <= nxt_k_s;
                            j_r           <= nxt_j_s;
                            line_addr_r   <= nxt_line_addr_s;
                            addr_r        <= nxt_addr_s;
                            strb_r        <= sg_strb_s;
                            first_r       <= nxt_first_s;
                            last_r        <= nxt_last_s;
                            last_packet_r <= nxt_last_packet_s;
                        end
                    end else begin
                        state_r <= SEQ_RUN;
                    end
                end
                SEQ_DONE: begin
                    state_r <= SEQ_IDLE;
                    flags_r <= '{busy: 1'b0, done: 1'b0};
                end
                default: begin
                    state_r <= SEQ_IDLE;
                    flags_r <= '{busy: 1'b0, done: 1'b0};
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Drive outputs; enable and strb_valid are the only combinational fields.
    always_comb begin
        addr_o             = addr_r;
        addr_valid_o       = valid_r;
        strb_o             = strb_r;
        busy_o             = flags_r.busy;
        done_o             = flags_r.done;
        ctrl_o.enable      = enable_i;
        ctrl_o.strb_valid  = valid_r & (first_r | last_r);
        ctrl_o.realign     = realign_r;
        ctrl_o.first       = first_r;
        ctrl_o.last        = last_r;
        ctrl_o.last_packet = last_packet_r;
        ctrl_o.line_length = line_length_r;
    end

endmodule

// File: tb/tb_hwpe_stream_realign_sequencer.sv
module tb_hwpe_stream_realign_sequencer;
    import hwpe_stream_package::*;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          clear_i;
    logic          enable_i;
    logic          start_i;
    logic [31:0]   base_addr_i;
    logic [15:0]   line_len_i;
    logic [31:0]   line_stride_i;
    logic [15:0]   n_lines_i;
    logic [31:0]   addr_o;
    logic          addr_valid_o;
    logic          addr_ready_i;
    ctrl_realign_t ctrl_o;
    logic [3:0]    strb_o;
    logic          busy_o;
    logic          done_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic        first;
        logic        last;
        logic        last_packet;
        logic        realign;
        logic [15:0] line_length;
    } exp_t;

    exp_t sb_q[$];

    hwpe_stream_realign_sequencer #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .enable_i      (enable_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .line_len_i    (line_len_i),
        .line_stride_i (line_stride_i),
        .n_lines_i     (n_lines_i),
        .addr_o        (addr_o),
        .addr_valid_o  (addr_valid_o),
        .addr_ready_i  (addr_ready_i),
        .ctrl_o        (ctrl_o),
        .strb_o        (strb_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: enumerate every word of the job into the scoreboard.
    task automatic push_job(input logic [31:0] base, input logic [15:0] len,
                            input logic [15:0] lines, input logic [31:0] stride);
        int   off;
        int   w;
        int   e;
        exp_t it;
        logic [3:0] m;
        logic [3:0] head;
        logic [3:0] tl;
        off = int'(base[1:0]);
        w   = (off + int'(len) + 3) / 4;
        e   = (off + int'(len)) % 4;
        if (len == 16'd0 || lines == 16'd0) return;
        for (int j = 0; j < int'(lines); j++) begin
            for (int k = 0; k < w; k++) begin
                head = 4'hF;
                head = head << off;
                tl   = 4'hF;
                tl   = tl >> (4 - e);
                m    = 4'hF;
                if (k == 0) m = m & head;
                if (k == w - 1 && e != 0) m = m & tl;
                it.addr        = (base & 32'hFFFF_FFFC) + 32'(j) * (stride & 32'hFFFF_FFFC) + 32'(k * 4);
                it.strb        = m;
                it.first       = (k == 0);
                it.last        = (k == w - 1);
                it.last_packet = (k == w - 1) && (j == int'(lines) - 1);
                it.realign     = (off != 0);
                it.line_length = 16'(w - ((off != 0) ? 1 : 0));
                sb_q.push_back(it);
            end
        end
    endtask

    task automatic run_job(input logic [31:0] base, input logic [15:0] len, input logic [15:0] lines,
                           input logic [31:0] stride, input bit rnd, input bit glitch,
                           input int abort_after, input bit abort_rst, input string tag);
        exp_t          it;
        int            hs;
        int            since_last;
        bit            prev_stall;
        bit            got_done;
        bit            saw;
        bit            first_iter;
        logic [31:0]   pa;
        logic [3:0]    ps;
        ctrl_realign_t pc;
        hs = 0; since_last = -1; prev_stall = 1'b0; got_done = 1'b0; first_iter = 1'b1;
        pa = 32'd0; ps = 4'd0; pc = '0;
        push_job(base, len, lines, stride);
        @(posedge clk_i); #1;
        base_addr_i = base; line_len_i = len; n_lines_i = lines; line_stride_i = stride;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        // scramble config inputs: the DUT must work from its latched copy
        base_addr_i = 32'h0BAD_F00D; line_len_i = 16'd3; n_lines_i = 16'd9; line_stride_i = 32'h44;
        addr_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_i);
            if (first_iter) begin
                check({tag, " busy"}, busy_o, 1'b1);
                first_iter = 1'b0;
            end
            if (since_last >= 0) since_last++;
            if (prev_stall) begin
                check({tag, " stall addr"}, addr_o, pa);
                check({tag, " stall strb"}, strb_o, ps);
                check({tag, " stall ctrl"}, ctrl_o, pc);
            end
            if (done_o) begin
                got_done = 1'b1;
                check({tag, " done latency"}, since_last, 1);
                break;
            end
            if (addr_valid_o && addr_ready_i) begin
                check({tag, " queue nonempty"}, (sb_q.size() != 0), 1'b1);
                if (sb_q.size() != 0) begin
                    it = sb_q.pop_front();
                    check({tag, " addr"}, addr_o, it.addr);
                    check({tag, " strb"}, strb_o, it.strb);
                    check({tag, " flags"}, {ctrl_o.first, ctrl_o.last, ctrl_o.last_packet, ctrl_o.realign},
                          {it.first, it.last, it.last_packet, it.realign});
                    check({tag, " strb_valid"}, ctrl_o.strb_valid, it.first | it.last);
                    check({tag, " line_length"}, ctrl_o.line_length, it.line_length);
                    if (it.last_packet) since_last = 0;
                end
                hs++;
                if (abort_after != 0 && hs == abort_after) begin
                    @(posedge clk_i); #1;
                    addr_ready_i = 1'b0;
                    if (abort_rst) rst_i = 1'b1;
                    else clear_i = 1'b1;
                    @(posedge clk_i); #1;
                    rst_i = 1'b0; clear_i = 1'b0;
                    @(negedge clk_i);
                    check({tag, " abort valid"}, addr_valid_o, 1'b0);
                    check({tag, " abort busy"}, busy_o, 1'b0);
                    saw = 1'b0;
                    repeat (4) begin
                        @(negedge clk_i);
                        saw = saw | done_o;
                    end
                    check({tag, " abort no done"}, saw, 1'b0);
                    sb_q.delete();
                    return;
                end
            end
            prev_stall = addr_valid_o && !addr_ready_i;
            pa = addr_o; ps = strb_o; pc = ctrl_o;
            @(posedge clk_i); #1;
            addr_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (glitch && hs == 2) begin
                start_i = 1'b1;
                base_addr_i = 32'h0000_7773;
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        check({tag, " done seen"}, got_done, 1'b1);
        check({tag, " all words issued"}, sb_q.size(), 0);
        @(negedge clk_i);
        check({tag, " done one cycle"}, {done_o, busy_o}, 2'b00);
        sb_q.delete();
    endtask

    // Empty job: no request, done pulse two cycles after the start cycle.
    task automatic empty_job(input logic [15:0] len, input logic [15:0] lines, input string tag);
        @(posedge clk_i); #1;
        base_addr_i = 32'h0000_5002; line_len_i = len; n_lines_i = lines; line_stride_i = 32'h10;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        check({tag, " c+1 done/busy/valid"}, {done_o, busy_o, addr_valid_o}, 3'b010);
        @(negedge clk_i);
        check({tag, " c+2 done/valid"}, {done_o, addr_valid_o}, 2'b10);
        @(negedge clk_i);
        check({tag, " c+3 done/busy"}, {done_o, busy_o}, 2'b00);
    endtask

    initial begin
        ctrl_realign_t rc;
        rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b1; start_i = 1'b0;
        base_addr_i = 32'd0; line_len_i = 16'd0; n_lines_i = 16'd0; line_stride_i = 32'd0;
        addr_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        rc = '0;
        rc.enable = 1'b1;
        check("reset addr", addr_o, 32'd0);
        check("reset valid", addr_valid_o, 1'b0);
        check("reset strb", strb_o, 4'hF);
        check("reset ctrl", ctrl_o, rc);
        check("reset busy/done", {busy_o, done_o}, 2'b00);
        enable_i = 1'b0;
        #1;
        check("enable forward", ctrl_o.enable, 1'b0);
        enable_i = 1'b1;

        run_job(32'h0000_1002, 16'd8, 16'd2, 32'h20, 1'b0, 1'b0, 0, 1'b0, "unaligned");
        run_job(32'h0000_2000, 16'd6, 16'd1, 32'h40, 1'b0, 1'b0, 0, 1'b0, "aligned");
        run_job(32'h0000_3001, 16'd2, 16'd1, 32'h00, 1'b0, 1'b0, 0, 1'b0, "single");
        run_job(32'h0000_1002, 16'd8, 16'd2, 32'h20, 1'b1, 1'b1, 0, 1'b0, "backpressure");
        run_job(32'h0000_1002, 16'd8, 16'd2, 32'h20, 1'b0, 1'b0, 3, 1'b0, "clear");
        run_job(32'h0000_1002, 16'd8, 16'd2, 32'h20, 1'b0, 1'b0, 0, 1'b0, "after clear");
        empty_job(16'd8, 16'd0, "zero lines");
        empty_job(16'd0, 16'd3, "zero len");
        run_job(32'h0000_4003, 16'd9, 16'd3, 32'h18, 1'b1, 1'b0, 2, 1'b1, "reset abort");
        run_job(32'hFFFF_FFF9, 16'd10, 16'd2, 32'h13, 1'b1, 1'b0, 0, 1'b0, "wrap");
        run_job(32'h0000_6004, 16'd12, 16'd3, 32'h0C, 1'b1, 1'b0, 0, 1'b0, "aligned multi");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
